wb_sram_bridge: RTL and testbench
=================================

# wb_sram_bridge

Wishbone classic slave that drives port 0 (RW) of the `sky130_sram_2kbyte_1rw1r_32x512_8` macro inside `user_project_wrapper`. It lets the management SoC read and write the 2 KB SRAM with byte masks over its Wishbone bus. It replaces direct logic-analyzer control of the macro pins. An optional debug read channel drives macro port 1 (R).

## Interface
Parameters:
- `BASE_ADDR`, default 32'h3000_0000: byte base address of the window; only bits [31:11] are compared.

Ports:
- `wb_clk_i` in 1: single clock for the bridge. Macro `clk0`/`clk1` are tied to it at wrapper level.
- `wb_rst_i` in 1: reset, synchronous, active-high.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i` in 1 each: Wishbone cycle, strobe and write enable.
- `wbs_sel_i` in 4: byte selects.
- `wbs_adr_i` in 32: byte address.
- `wbs_dat_i` in 32: write data.
- `wbs_ack_o` out 1: ack, one-cycle pulse.
- `wbs_dat_o` out 32: read data; 0 whenever ack is low.
- `sram_csb0`, `sram_web0` out 1 each: port 0 chip select and write enable, both active-low.
- `sram_wmask0` out 4, `sram_addr0` out 9, `sram_din0` out 32: port 0 byte mask, word address and write data.
- `sram_dout0` in 32: port 0 read data.
- `sram_csb1` out 1, `sram_addr1` out 9: port 1 chip select and address.
- `sram_dout1` in 32: port 1 read data.
- `dbg_req_i` in 1, `dbg_addr_i` in 9: debug read request and word address.
- `dbg_valid_o` out 1, `dbg_data_o` out 32: debug read result.

## Operation
- Hit: `cyc & stb & (adr[31:11] == BASE_ADDR[31:11])`. A miss is ignored: no ack, macro idle.
- Word address = `adr[10:2]`. `adr[1:0]` is ignored.
- All macro-facing outputs are registered.
- FSM states:
  - IDLE: on a hit with `we=1` go to WR; with `we=0` go to RD. Capture address, data and sel.
  - WR: `csb0=0`, `web0=0`, `wmask0=sel`, `din0=dat`; assert ack this cycle; next state IDLE.
  - RD: `csb0=0`, `web0=1`; next state RWAIT.
  - RWAIT: `csb0=1`; register `sram_dout0`; next state RACK.
  - RACK: ack=1 with the registered data; next state IDLE.
- Write with `sel=0`: still acked, `wmask0=0`, memory unchanged.
- Reads ignore `sel` and return all 32 bits.
- Abort: if `cyc_i` is low in RWAIT or RACK, go to IDLE with no ack. A write is already committed once WR is entered.
- Idle macro values: `csb0=1`, `web0=1`; `wmask0`, `addr0` and `din0` hold their last values.

## Timing
- Reset (cycle after `wb_rst_i` sampled high): state IDLE, `wbs_ack_o=0`, `wbs_dat_o=0`, `csb0=1`, `web0=1`, `wmask0=0`, `addr0=0`, `din0=0`, `csb1=1`, `addr1=0`, `dbg_valid_o=0`, `dbg_data_o=0`.
- Reset during any state aborts immediately; no ack follows.
- A request sampled in cycle N is handled as follows:
  - Write: ack in N+1, the same cycle `csb0` is low; the macro captures at the N+1/N+2 edge.
  - Read: `csb0` low in N+1; `dout0` sampled at the end of N+2; ack with data in N+3.
- The master drops `stb` in the cycle after ack. The FSM is in IDLE that cycle, so a single request is never double-accepted.
- Throughput: back-to-back writes every 2 cycles; back-to-back reads every 4 cycles.

## Configuration
- `WB_SRAM_DBG_PORT_EN` defined: port 1 debug read channel.
  - A `dbg_req_i` sampled while the channel is idle latches `dbg_addr_i`.
  - `csb1=0` in the next cycle.
  - `dbg_data_o` is registered and `dbg_valid_o` pulses for 1 cycle, 3 cycles after the request.
  - Requests arriving while the channel is busy are dropped.
  - The channel is independent of the Wishbone FSM.
  - A port-1 read of the address being written on port 0 in the same cycle returns undefined data; the bridge does not arbitrate.
- Macro undefined: `sram_csb1=1`, `sram_addr1=0`, `dbg_valid_o=0`, `dbg_data_o=0` constant; `dbg_*` inputs unused.

## Test plan
- Reset then idle: all outputs at their reset values, `csb0=1` for 20 cycles with no bus activity.
- Write 0xDEADBEEF to 0x3000_0010 with sel=4'hF -> ack at N+1, `addr0=4`, `wmask0=F`. Read of the same address -> ack at N+3 with `dat_o=0xDEADBEEF`.
- Byte write of 0x000000AA with sel=4'b0001 to word 4 -> read returns 0xDEADBEAA. A write with sel=0 leaves the value unchanged and is still acked.
- Miss at 0x3000_0800 -> no ack for 10 cycles, `csb0` stays 1.
- Read to word 511 (0x3000_07FC) with `cyc` dropped in RWAIT -> no ack, FSM back in IDLE. A following write at word 0 completes normally.
- With `WB_SRAM_DBG_PORT_EN`: `dbg_req` with addr=4 -> `dbg_valid` pulse 3 cycles later with the stored word. A second `dbg_req` one cycle after the first is dropped.

Source files
------------

// File: rtl/wb_sram_bridge_if.sv
// Wishbone classic slave-side bus bundle for wb_sram_bridge.
interface wb_sram_bridge_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_sram_bridge.sv
// Wishbone classic slave onto port 0 of the 32x512 sky130 SRAM macro.
// Define WB_SRAM_DBG_PORT_EN to enable the port-1 debug read channel.
module wb_sram_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  wb_sram_bridge_if.slave wbs,
  output logic        sram_csb0,
  output logic        sram_web0,
  output logic [3:0]  sram_wmask0,
  output logic [8:0]  sram_addr0,
  output logic [31:0] sram_din0,
  input  logic [31:0] sram_dout0,
  output logic        sram_csb1,
  output logic [8:0]  sram_addr1,
  input  logic [31:0] sram_dout1,
  input  logic        dbg_req_i,
  input  logic [8:0]  dbg_addr_i,
  output logic        dbg_valid_o,
  output logic [31:0] dbg_data_o
);

  typedef enum logic [2:0] {ST_IDLE, ST_WR, ST_RD, ST_RWAIT, ST_RACK} state_e;

  state_e      state_q, state_d;
  logic        csb0_q, csb0_d;
  logic        web0_q, web0_d;
  logic [3:0]  wmask0_q, wmask0_d;
  logic [8:0]  addr0_q, addr0_d;
  logic [31:0] din0_q, din0_d;
  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;
  logic        hit;
  logic        unused_adr;

  assign hit = wbs.wbs_cyc_i & wbs.wbs_stb_i &
               (wbs.wbs_adr_i[31:11] == BASE_ADDR[31:11]);
  assign unused_adr = ^wbs.wbs_adr_i[1:0];

  // Macro-facing values are computed for the state being entered, so the
  // registered pins line up with that state's cycle.
  always_comb begin
    state_d  = state_q;
    csb0_d   = 1'b1;
    web0_d   = 1'b1;
    wmask0_d = wmask0_q;
    addr0_d  = addr0_q;
    din0_d   = din0_q;
    ack_d    = 1'b0;
    rdata_d  = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          addr0_d = wbs.wbs_adr_i[10:2];
          csb0_d  = 1'b0;
          if (wbs.wbs_we_i) begin
            state_d  = ST_WR;
            web0_d   = 1'b0;
            wmask0_d = wbs.wbs_sel_i;
            din0_d   = wbs.wbs_dat_i;
            ack_d    = 1'b1;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_WR:   state_d = ST_IDLE;
      ST_RD:   state_d = ST_RWAIT;
      ST_RWAIT: begin
        if (!wbs.wbs_cyc_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RACK;
          rdata_d = sram_dout0;
          ack_d   = 1'b1;
        end
      end
      ST_RACK: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_IDLE;
      csb0_q   <= 1'b1;
      web0_q   <= 1'b1;
      wmask0_q <= '0;
      addr0_q  <= '0;
      din0_q   <= '0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      csb0_q   <= csb0_d;
      web0_q   <= web0_d;
      wmask0_q <= wmask0_d;
      addr0_q  <= addr0_d;
      din0_q   <= din0_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
    end
  end

  // Gating with cyc lets a master that drops cyc during RACK see no ack.
  assign wbs.wbs_ack_o = ack_q & wbs.wbs_cyc_i;
  assign wbs.wbs_dat_o = (wbs.wbs_ack_o && state_q == ST_RACK) ? rdata_q : 32'h0;

  assign sram_csb0   = csb0_q;
  assign sram_web0   = web0_q;
  assign sram_wmask0 = wmask0_q;
  assign sram_addr0  = addr0_q;
  assign sram_din0   = din0_q;

`ifdef WB_SRAM_DBG_PORT_EN
  logic [1:0]  dbg_cnt_q, dbg_cnt_d;
  logic        csb1_q, csb1_d;
  logic [8:0]  addr1_q, addr1_d;
  logic        dbg_valid_q, dbg_valid_d;
  logic [31:0] dbg_data_q, dbg_data_d;

  // cnt 1: macro selected; cnt 2: port-1 data valid, captured for next cycle.
  always_comb begin
    dbg_cnt_d   = dbg_cnt_q;
    csb1_d      = 1'b1;
    addr1_d     = addr1_q;
    dbg_valid_d = 1'b0;
    dbg_data_d  = dbg_data_q;
    case (dbg_cnt_q)
      2'd0: begin
        if (dbg_req_i) begin
          dbg_cnt_d = 2'd1;
          csb1_d    = 1'b0;
          addr1_d   = dbg_addr_i;
        end
      end
      2'd1: dbg_cnt_d = 2'd2;
      default: begin
        dbg_cnt_d   = 2'd0;
        dbg_valid_d = 1'b1;
        dbg_data_d  = sram_dout1;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      dbg_cnt_q   <= 2'd0;
      csb1_q      <= 1'b1;
      addr1_q     <= '0;
      dbg_valid_q <= 1'b0;
      dbg_data_q  <= '0;
    end else begin
      dbg_cnt_q   <= dbg_cnt_d;
      csb1_q      <= csb1_d;
      addr1_q     <= addr1_d;
      dbg_valid_q <= dbg_valid_d;
      dbg_data_q  <= dbg_data_d;
    end
  end

  assign sram_csb1   = csb1_q;
  assign sram_addr1  = addr1_q;
  assign dbg_valid_o = dbg_valid_q;
  assign dbg_data_o  = dbg_data_q;
`else
  logic unused_dbg;

  assign unused_dbg  = ^{dbg_req_i, dbg_addr_i, sram_dout1};
  assign sram_csb1   = 1'b1;
  assign sram_addr1  = 9'h0;
  assign dbg_valid_o = 1'b0;
  assign dbg_data_o  = 32'h0;
`endif

endmodule

// File: tb/tb_wb_sram_bridge.sv
// Self-checking bench for wb_sram_bridge: behavioural macro plus byte-merge reference memory.
module tb_wb_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        csb0, web0, csb1;
  logic [3:0]  wmask0;
  logic [8:0]  addr0, addr1, dbg_addr;
  logic [31:0] din0, dout0, dout1, dbg_data;
  logic        dbg_req, dbg_valid;

  int checks = 0;
  int failures = 0;

  logic [31:0] mac_mem [512];
  logic [31:0] ref_mem [512];

  always #5 clk = ~clk;

  wb_sram_bridge_if bus ();

  wb_sram_bridge #(.BASE_ADDR(32'h3000_0000)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs(bus),
    .sram_csb0(csb0), .sram_web0(web0), .sram_wmask0(wmask0),
    .sram_addr0(addr0), .sram_din0(din0), .sram_dout0(dout0),
    .sram_csb1(csb1), .sram_addr1(addr1), .sram_dout1(dout1),
    .dbg_req_i(dbg_req), .dbg_addr_i(dbg_addr),
    .dbg_valid_o(dbg_valid), .dbg_data_o(dbg_data)
  );

  // Behavioural 1rw1r macro: synchronous capture, data out after the edge.
  always @(posedge clk) begin
    if (!csb0) begin
      if (!web0) begin
        for (int b = 0; b < 4; b++)
          if (wmask0[b]) mac_mem[addr0][8*b +: 8] <= din0[8*b +: 8];
      end else begin
        dout0 <= mac_mem[addr0];
      end
    end
    if (!csb1) dout1 <= mac_mem[addr1];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[8*b +: 8] = dat[8*b +: 8];
    return r;
  endfunction

  // One Wishbone request held until ack or a 10-cycle bound; latencies are
  // counted from the cycle the request is presented (-1 = never seen).
  task automatic bus_txn(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                         input logic [3:0] sel, output int ack_lat, output int csb_lat,
                         output logic [31:0] rdat, output logic [3:0] wm,
                         output logic [8:0] a0, output logic [31:0] d0, output logic web_at);
    @(posedge clk); #1;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_adr_i = adr;  bus.wbs_dat_i = dat;  bus.wbs_sel_i = sel;
    ack_lat = -1; csb_lat = -1; rdat = 'x; wm = 'x; a0 = 'x; d0 = 'x; web_at = 1'bx;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (csb0 === 1'b0 && csb_lat < 0) begin
        csb_lat = k; wm = wmask0; a0 = addr0; d0 = din0; web_at = web0;
      end
      if (bus.wbs_ack_o === 1'b1) begin
        ack_lat = k; rdat = bus.wbs_dat_o;
        break;
      end
    end
    @(posedge clk); #1;
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    int al, cl; logic [31:0] rd, d0; logic [3:0] wm; logic [8:0] a0; logic w;
    bus_txn(adr, 1'b1, dat, sel, al, cl, rd, wm, a0, d0, w);
    check("wr_ack_lat", al, 1);
    check("wr_csb_lat", cl, 1);
    check("wr_web0", {31'h0, w}, 0);
    check("wr_addr0", {23'h0, a0}, {23'h0, adr[10:2]});
    check("wr_wmask0", {28'h0, wm}, {28'h0, sel});
    if (sel != 4'h0) check("wr_din0", d0, dat);
    ref_mem[adr[10:2]] = merge(ref_mem[adr[10:2]], dat, sel);
  endtask

  task automatic do_read(input logic [31:0] adr);
    int al, cl; logic [31:0] rd, d0; logic [3:0] wm; logic [8:0] a0; logic w;
    bus_txn(adr, 1'b0, $urandom, 4'($urandom), al, cl, rd, wm, a0, d0, w);
    check("rd_ack_lat", al, 3);
    check("rd_csb_lat", cl, 1);
    check("rd_web0", {31'h0, w}, 1);
    check("rd_addr0", {23'h0, a0}, {23'h0, adr[10:2]});
    check("rd_data", rd, ref_mem[adr[10:2]]);
  endtask

  initial begin
    int al, cl, bad, acks, pulses, pulse_k;
    logic [31:0] rd, d0, pdata;
    logic [3:0] wm;
    logic [8:0] a0;
    logic w;
    logic [31:0] words [8];

    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = 32'h0; bus.wbs_dat_i = 32'h0;
    dbg_req = 1'b0; dbg_addr = 9'h0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", {31'h0, bus.wbs_ack_o}, 0);
    check("rst_dat_o", bus.wbs_dat_o, 0);
    check("rst_csb0", {31'h0, csb0}, 1);
    check("rst_web0", {31'h0, web0}, 1);
    check("rst_wmask0", {28'h0, wmask0}, 0);
    check("rst_addr0", {23'h0, addr0}, 0);
    check("rst_din0", din0, 0);
    check("rst_csb1", {31'h0, csb1}, 1);
    check("rst_addr1", {23'h0, addr1}, 0);
    check("rst_dbg_valid", {31'h0, dbg_valid}, 0);
    check("rst_dbg_data", dbg_data, 0);
    @(posedge clk); #1 rst = 1'b0;

    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (csb0 !== 1'b1 || bus.wbs_ack_o !== 1'b0) bad++;
    end
    check("idle_quiet", bad, 0);

    do_write(32'h3000_0010, 32'hDEAD_BEEF, 4'hF);
    do_read(32'h3000_0010);
    @(negedge clk);
    check("post_rd_ack", {31'h0, bus.wbs_ack_o}, 0);
    check("post_rd_dat", bus.wbs_dat_o, 0);

    do_write(32'h3000_0010, 32'h0000_00AA, 4'b0001);
    do_read(32'h3000_0010);
    check("byte_merge_ref", ref_mem[4], 32'hDEAD_BEAA);
    do_write(32'h3000_0012, 32'h1234_5678, 4'b0000);
    do_read(32'h3000_0010);

    bus_txn(32'h3000_0800, 1'b1, 32'h5555_5555, 4'hF, al, cl, rd, wm, a0, d0, w);
    check("miss_hi_ack", al, -1);
    check("miss_hi_csb", cl, -1);
    bus_txn(32'h2FFF_FFFC, 1'b0, 32'h0, 4'hF, al, cl, rd, wm, a0, d0, w);
    check("miss_lo_ack", al, -1);
    check("miss_lo_csb", cl, -1);
    do_read(32'h3000_0010);

    // Read of word 511 abandoned while the FSM waits for macro data.
    @(posedge clk); #1;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
    bus.wbs_adr_i = 32'h3000_07FC;
    @(negedge clk);
    @(negedge clk);
    check("abort_csb0", {31'h0, csb0}, 0);
    check("abort_addr0", {23'h0, addr0}, 9'd511);
    @(posedge clk); #1 bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.wbs_ack_o !== 1'b0) acks++;
    end
    check("abort_rwait_noack", acks, 0);
    do_write(32'h3000_0000, 32'hCAFE_F00D, 4'hF);
    do_read(32'h3000_0000);

    // Cycle dropped in the ack cycle itself.
    @(posedge clk); #1;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
    bus.wbs_adr_i = 32'h3000_0000;
    repeat (3) @(posedge clk);
    #1 bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    acks = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.wbs_ack_o !== 1'b0 || bus.wbs_dat_o !== 32'h0) acks++;
    end
    check("abort_rack_noack", acks, 0);
    do_read(32'h3000_0010);

    // Debug channel: request at k=0, a second one at k=1 must be dropped.
    pulses = 0; pulse_k = -1; pdata = 32'h0; bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      dbg_req  = (k < 2);
      dbg_addr = (k == 0) ? 9'd4 : 9'd7;
      @(negedge clk);
      if (dbg_valid === 1'b1) begin
        pulses++;
        if (pulse_k < 0) begin pulse_k = k; pdata = dbg_data; end
      end
`ifdef WB_SRAM_DBG_PORT_EN
      if (k == 1 && (csb1 !== 1'b0 || addr1 !== 9'd4)) bad++;
`else
      if (csb1 !== 1'b1 || addr1 !== 9'd0 || dbg_data !== 32'h0) bad++;
`endif
    end
    dbg_req = 1'b0;
    check("dbg_port1_pins", bad, 0);
`ifdef WB_SRAM_DBG_PORT_EN
    check("dbg_pulses", pulses, 1);
    check("dbg_latency", pulse_k, 3);
    check("dbg_data", pdata, ref_mem[4]);
`else
    check("dbg_disabled_pulses", pulses, 0);
`endif

    // Randomised traffic over a handful of words, each fully initialised first.
    for (int i = 0; i < 8; i++) begin
      words[i] = 32'h3000_0000 | ({23'h0, 9'($urandom_range(0, 511))} << 2);
      do_write(words[i], $urandom, 4'hF);
    end
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = words[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) do_write(a, $urandom, 4'($urandom));
      else do_read(a);
    end
    for (int i = 0; i < 8; i++) do_read(words[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
